spi_rx: RTL and testbench
=========================

SPI_RX -- requirements
Module: spi_rx

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, giving the sclk half-period in clk cycles; legal range 3..255.
REQ-002 The block SHALL have parameter DATA_W, default 16, giving bits per frame; the audio path uses 16.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous active-low reset; 0 sampled on a clk edge resets the block.
REQ-005 start  input  1  frame request; sampled only in IDLE.
REQ-006 miso  input  1  serial data from the SPI transmitter, MSB first.
REQ-007 sclk  output  1  SPI clock; idles low; generated internally.
REQ-008 sel  output  1  active-low chip select to the transmitter.
REQ-009 data_out  output  DATA_W  last received sample; stable while valid_out=1.
REQ-010 valid_out  output  1  sample available.
REQ-011 ready_in  input  1  consumer accepts data_out when valid_out=1 and ready_in=1.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 overrun  output  1  one-cycle pulse when an unconsumed sample is overwritten.

Function
REQ-014 States: IDLE, LEAD, SHIFT, TRAIL, GAP; all outputs registered.
REQ-015 IDLE: sel=1, sclk=0; start=1 moves to LEAD, and sel=0 from the next cycle (T+1, T = cycle start was sampled).
REQ-016 LEAD: sel=0, sclk=0 for exactly CLK_DIV cycles, giving the transmitter time to load its first bit.
REQ-017 SHIFT: half-period counter runs 0..CLK_DIV-1; sclk toggles when the counter reaches CLK_DIV-1; first rising edge at T+1+CLK_DIV.
REQ-018 On each sclk 0->1 transition, miso SHALL be shifted into the LSB of the internal shift register (shift left), MSB received first.
REQ-019 SHIFT ends after exactly DATA_W rising and DATA_W falling sclk edges; sclk is 0 on exit.
REQ-020 TRAIL: sel=0, sclk=0 for CLK_DIV cycles; then sel=1.
REQ-021 At T+1+(2*DATA_W+2)*CLK_DIV, i.e. T+137 for the defaults, sel SHALL be 1, data_out SHALL hold the shift register, valid_out SHALL be 1, and state SHALL be GAP.
REQ-022 GAP: sel=1 for CLK_DIV cycles minimum; then IDLE; start is ignored in all states except IDLE.
REQ-023 valid_out SHALL stay 1 and data_out unchanged until a cycle with ready_in=1; valid_out is 0 the cycle after.
REQ-024 Frame completes while valid_out=1 and ready_in=0 in that cycle: data_out SHALL take the new sample, valid_out SHALL stay 1, and overrun SHALL pulse 1 for one cycle.
REQ-025 Frame completes in the same cycle as ready_in=1 with valid_out=1: old sample is consumed, new sample is loaded, valid_out stays 1, and there is no overrun.
REQ-026 start held high continuously SHALL produce back-to-back frames separated by the GAP plus one IDLE cycle.
REQ-027 The shift register and bit counter SHALL be DATA_W and clog2(DATA_W)+1 bits wide, with no wrap inside a frame.

Reset
REQ-028 reset=0 SHALL take effect at the next clk edge and dominate all other inputs.
REQ-029 Reset values: state IDLE, sel=1, sclk=0, data_out=0, valid_out=0, busy=0, overrun=0, shift register and counters 0.
REQ-030 reset asserted mid-frame SHALL abort the frame with no valid_out and no overrun; sel=1 from the following cycle.

Verification
REQ-031 CLK_DIV=4, transmitter model loaded with 16'hA5C3, start pulse at T -> sel low at T+1, 16 sclk periods of 8 cycles, data_out=16'hA5C3, valid_out=1 at T+137.
REQ-032 Two frames 16'h8001 then 16'h7FFE, ready_in held 0 -> second completion gives data_out=16'h7FFE and one overrun pulse; ready_in=1 then clears valid_out the next cycle.
REQ-033 ready_in=1 asserted exactly on the second completion cycle -> data_out=second sample, valid_out=1, overrun=0.
REQ-034 reset=0 for 1 cycle after the 7th sclk rising edge -> sel=1, sclk=0, valid_out=0 next cycle; a new start then receives 16'hFFFF correctly.
REQ-035 start pulsed during SHIFT and GAP -> ignored, exactly one frame produced; start held high -> periodic frames, sel high for at least CLK_DIV cycles between frames.
REQ-036 CLK_DIV=3 with miso alternating 16'h5555 -> data_out=16'h5555, with all sclk half-periods exactly 3 cycles.

Source files
------------

// File: rtl/spi_rx.sv
// SPI receive master: drives sel/sclk, shifts miso in MSB first on rising sclk,
// and hands each completed frame to a valid/ready consumer with overrun flagging.
module spi_rx #(
  parameter int CLK_DIV = 4,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              miso,
  output logic              sclk,
  output logic              sel,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              busy,
  output logic              overrun
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BITS_ALL = BW'(DATA_W);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    SHIFT = 3'd2,
    TRAIL = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sclk_q, sclk_d;
  logic              sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              overrun_q, overrun_d;
  logic              cnt_done;
  logic              frame_done;

  assign cnt_done = (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      sclk_q    <= 1'b0;
      sel_q     <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      sclk_q    <= sclk_d;
      sel_q     <= sel_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  // The LEAD->SHIFT transition is itself the first rising sclk edge, so every
  // rising edge (including that one) samples miso and bumps the bit count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    sclk_d     = sclk_q;
    sel_d      = sel_q;
    data_d     = data_q;
    valid_d    = valid_q;
    overrun_d  = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        sel_d  = 1'b1;
        if (start) begin
          state_d   = LEAD;
          sel_d     = 1'b0;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      LEAD: begin
        if (cnt_done) begin
          cnt_d     = '0;
          state_d   = SHIFT;
          sclk_d    = 1'b1;
          shift_d   = {shift_q[DATA_W-2:0], miso};
          bit_cnt_d = bit_cnt_q + BW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      SHIFT: begin
        if (cnt_done) begin
          cnt_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
          end else if (bit_cnt_q == BITS_ALL) begin
            state_d = TRAIL;
          end else begin
            sclk_d    = 1'b1;
            shift_d   = {shift_q[DATA_W-2:0], miso};
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TRAIL: begin
        if (cnt_done) begin
          cnt_d      = '0;
          state_d    = GAP;
          sel_d      = 1'b1;
          frame_done = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_done) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        sclk_d  = 1'b0;
        sel_d   = 1'b1;
      end
    endcase

    // A completing frame always wins the output register; a concurrent ready
    // consumes the old sample, so overrun only fires when nobody took it.
    if (frame_done) begin
      data_d    = shift_q;
      valid_d   = 1'b1;
      overrun_d = valid_q & ~ready_in;
    end else if (valid_q && ready_in) begin
      valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign sclk      = sclk_q;
  assign sel       = sel_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: frame-timing model checked every cycle plus directed
// scenarios with hand-computed values, and a CLK_DIV=3 instance for half-periods.
`timescale 1ns/1ps
module tb_spi_rx;

  localparam int D  = 4;
  localparam int W  = 16;
  localparam int D2 = 3;
  localparam int SEL_LOW_END = (2 * W + 2) * D;
  localparam int DONE_OFF    = SEL_LOW_END + 1;
  localparam int IDLE_OFF    = (2 * W + 3) * D + 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic miso = 1'b0;
  logic ready_in = 1'b0;
  logic sclk, sel, valid_out, busy, overrun;
  logic [W-1:0] data_out;

  logic start2 = 1'b0;
  logic miso2 = 1'b0;
  logic ready2 = 1'b0;
  logic sclk2, sel2, valid2, busy2, overrun2;
  logic [W-1:0] data2;

  int checks = 0;
  int failures = 0;

  spi_rx #(.CLK_DIV(D), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .start(start), .miso(miso), .sclk(sclk), .sel(sel),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in), .busy(busy),
    .overrun(overrun)
  );

  spi_rx #(.CLK_DIV(D2), .DATA_W(W)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .miso(miso2), .sclk(sclk2), .sel(sel2),
    .data_out(data2), .valid_out(valid2), .ready_in(ready2), .busy(busy2),
    .overrun(overrun2)
  );

  always #5 clk = ~clk;

  // Transmitter models: present the MSB when selected, next bit after each falling sclk.
  logic [W-1:0] tx_word = '0;
  int tx_falls = 0;
  always @(negedge sel) begin
    tx_falls = 0;
    miso = tx_word[W-1];
  end
  always @(negedge sclk) begin
    tx_falls++;
    if (tx_falls < W) miso = tx_word[W-1-tx_falls];
    else miso = 1'b0;
  end

  logic [W-1:0] tx_word2 = '0;
  int tx_falls2 = 0;
  always @(negedge sel2) begin
    tx_falls2 = 0;
    miso2 = tx_word2[W-1];
  end
  always @(negedge sclk2) begin
    tx_falls2++;
    if (tx_falls2 < W) miso2 = tx_word2[W-1-tx_falls2];
    else miso2 = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: each accepted start fixes a frame origin t0, and every
  // output follows from the cycle offset relative to it.
  int cyc = 0;
  int t0 = 0;
  bit m_active = 1'b0;
  bit m_valid = 1'b0;
  bit m_ovr = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_word = '0;
  bit cmp_en = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_active = 1'b0;
      m_valid  = 1'b0;
      m_ovr    = 1'b0;
      m_data   = '0;
    end else begin
      m_ovr = 1'b0;
      if (m_active && (cyc - t0) == DONE_OFF) begin
        m_ovr   = m_valid && !ready_in;
        m_data  = m_word;
        m_valid = 1'b1;
      end else if (m_valid && ready_in) begin
        m_valid = 1'b0;
      end
      if ((!m_active || (cyc - 1 - t0) >= IDLE_OFF) && start) begin
        m_active = 1'b1;
        t0 = cyc - 1;
        m_word = tx_word;
      end
    end
  end

  always @(negedge clk) begin
    int off;
    logic e_sel, e_sclk, e_busy;
    if (cmp_en) begin
      off    = cyc - t0;
      e_sel  = !(m_active && off >= 1 && off <= SEL_LOW_END);
      e_sclk = m_active && off >= D + 1 && off < D + 1 + 2 * W * D && (((off - D - 1) / D) % 2 == 0);
      e_busy = m_active && off >= 1 && off < IDLE_OFF;
      check("cmp_sel", 32'(sel), 32'(e_sel));
      check("cmp_sclk", 32'(sclk), 32'(e_sclk));
      check("cmp_busy", 32'(busy), 32'(e_busy));
      check("cmp_valid", 32'(valid_out), 32'(m_valid));
      check("cmp_overrun", 32'(overrun), 32'(m_ovr));
      check("cmp_data", 32'(data_out), 32'(m_data));
    end
  end

  // Event monitors for the directed checks.
  int sclk_rises = 0;
  int sel_rises = 0;
  int sel_low_cnt = 0;
  int ovr_cnt = 0;
  int hi_run = 0;
  int last_hi_run = 0;
  int min_hi_run = 1000;
  int last_fall_cyc = 0;
  int last_period = 0;
  logic sel_prev = 1'b1;
  int edges2 = 0;
  int last_edge2 = 0;
  int hp_bad = 0;
  logic sclk2_prev = 1'b0;

  always @(posedge sclk) sclk_rises++;
  always @(posedge sel) sel_rises++;

  always @(negedge clk) begin
    if (sel === 1'b0 && sel_prev === 1'b1) begin
      last_hi_run = hi_run;
      if (hi_run < min_hi_run) min_hi_run = hi_run;
      last_period = cyc - last_fall_cyc;
      last_fall_cyc = cyc;
    end
    hi_run = (sel === 1'b1) ? hi_run + 1 : 0;
    if (sel === 1'b0) sel_low_cnt++;
    if (overrun === 1'b1) ovr_cnt++;
    sel_prev = sel;
    if (sel2 === 1'b0 && sclk2 !== sclk2_prev) begin
      if (edges2 > 0 && (cyc - last_edge2) != D2) hp_bad++;
      edges2++;
      last_edge2 = cyc;
    end
    sclk2_prev = sclk2;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle T+1, T being the cycle in which start was high.
  task automatic apply_stimulus(input logic [W-1:0] word);
    @(posedge clk);
    #1;
    tx_word = word;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 400 && busy !== 1'b0; i++) wait_cycles(1);
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic consume();
    ready_in = 1'b1;
    wait_cycles(1);
    ready_in = 1'b0;
  endtask

  initial begin
    int r0, o0, f0, lo0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    cmp_en = 1'b1;
    check("rst_sel", 32'(sel), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);

    // Single frame A5C3 with exact completion latency.
    r0 = sclk_rises;
    lo0 = sel_low_cnt;
    apply_stimulus(16'hA5C3);
    check("s1_sel_T1", 32'(sel), 32'd0);
    check("s1_busy_T1", 32'(busy), 32'd1);
    wait_cycles(136);
    check("s1_data", 32'(data_out), 32'h0000A5C3);
    check("s1_valid", 32'(valid_out), 32'd1);
    check("s1_sel", 32'(sel), 32'd1);
    check("s1_rises", 32'(sclk_rises - r0), 32'd16);
    check("s1_sel_low_cycles", 32'(sel_low_cnt - lo0), 32'd136);
    consume();
    check("s1_valid_cleared", 32'(valid_out), 32'd0);

    // Two frames with no consumer: second overwrites and pulses overrun once.
    wait_idle("s2_idle_a");
    apply_stimulus(16'h8001);
    wait_cycles(136);
    check("s2_data1", 32'(data_out), 32'h00008001);
    wait_idle("s2_idle_b");
    o0 = ovr_cnt;
    apply_stimulus(16'h7FFE);
    wait_cycles(136);
    check("s2_data2", 32'(data_out), 32'h00007FFE);
    check("s2_valid", 32'(valid_out), 32'd1);
    check("s2_overrun", 32'(overrun), 32'd1);
    wait_cycles(1);
    check("s2_overrun_once", 32'(overrun), 32'd0);
    consume();
    check("s2_valid_cleared", 32'(valid_out), 32'd0);
    check("s2_overrun_count", 32'(ovr_cnt - o0), 32'd1);

    // Ready asserted exactly in the completion cycle: no overrun.
    wait_idle("s3_idle_a");
    apply_stimulus(16'h8001);
    wait_cycles(136);
    wait_idle("s3_idle_b");
    apply_stimulus(16'h7FFE);
    wait_cycles(135);
    ready_in = 1'b1;
    wait_cycles(1);
    ready_in = 1'b0;
    check("s3_data", 32'(data_out), 32'h00007FFE);
    check("s3_valid", 32'(valid_out), 32'd1);
    check("s3_overrun", 32'(overrun), 32'd0);
    consume();

    // Reset after the 7th rising sclk aborts the frame; the next one is clean.
    wait_idle("s4_idle");
    r0 = sclk_rises;
    apply_stimulus(16'h1234);
    for (int i = 0; i < 200 && (sclk_rises - r0) < 7; i++) wait_cycles(1);
    check("s4_seven_rises", 32'(sclk_rises - r0), 32'd7);
    reset = 1'b0;
    wait_cycles(1);
    reset = 1'b1;
    check("s4_sel", 32'(sel), 32'd1);
    check("s4_sclk", 32'(sclk), 32'd0);
    check("s4_valid", 32'(valid_out), 32'd0);
    check("s4_busy", 32'(busy), 32'd0);
    apply_stimulus(16'hFFFF);
    wait_cycles(136);
    check("s4_data", 32'(data_out), 32'h0000FFFF);
    check("s4_valid_new", 32'(valid_out), 32'd1);
    consume();

    // Start pulses in SHIFT and GAP are ignored.
    wait_idle("s5_idle_a");
    ready_in = 1'b1;
    f0 = sel_rises;
    apply_stimulus(16'h3C96);
    wait_cycles(19);
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    wait_cycles(117);
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
    wait_idle("s5_idle_b");
    wait_cycles(20);
    check("s5_one_frame", 32'(sel_rises - f0), 32'd1);
    check("s5_still_idle", 32'(busy), 32'd0);

    // Start held high: three frames, 141-cycle period, 5 idle-select cycles between.
    f0 = sel_rises;
    min_hi_run = 1000;
    start = 1'b1;
    tx_word = 16'h0F0F;
    wait_cycles(423);
    start = 1'b0;
    wait_idle("s5_idle_c");
    check("s5_held_frames", 32'(sel_rises - f0), 32'd3);
    check("s5_period", 32'(last_period), 32'd141);
    check("s5_gap_run", 32'(last_hi_run), 32'd5);
    check("s5_min_gap", 32'(min_hi_run >= D), 32'd1);
    ready_in = 1'b0;

    // CLK_DIV=3 instance: alternating data, every half-period exactly 3 cycles.
    edges2 = 0;
    hp_bad = 0;
    @(posedge clk);
    #1;
    tx_word2 = 16'h5555;
    start2 = 1'b1;
    wait_cycles(1);
    start2 = 1'b0;
    check("s6_sel_T1", 32'(sel2), 32'd0);
    wait_cycles((2 * W + 2) * D2);
    check("s6_data", 32'(data2), 32'h00005555);
    check("s6_valid", 32'(valid2), 32'd1);
    check("s6_sel", 32'(sel2), 32'd1);
    check("s6_edges", 32'(edges2), 32'd32);
    check("s6_half_periods", 32'(hp_bad), 32'd0);

    wait_cycles(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
